// File: rtl/booth_mult.sv
// booth_mult: sequential signed multiplier, radix-4 Booth, one digit per cycle
//   clock, reset (async, active-high)
//   data_operandA/B: two's-complement operands, sampled on the start edge
//   ctrl_MULT: start request, honoured in IDLE and DONE
//   data_result/data_exception: low product word and signed overflow, held until next DONE
//   data_resultRDY: one-cycle pulse in DONE; busy: high in RUN
module booth_mult #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);
  localparam int AW = WIDTH + 2;
  localparam int PW = 2 * WIDTH + 3;
  localparam int CW = $clog2(WIDTH / 2 + 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [AW-1:0] a_q, a_d;
  logic [PW-1:0] p_q, p_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic exc_q, exc_d;
  logic [AW-1:0] a2, digit, sum;
  logic [2*WIDTH-1:0] prod;
  logic start;
  always_comb begin
    start = ctrl_MULT && (state_q != RUN);
    a2 = {a_q[AW-2:0], 1'b0};
    unique case (p_q[2:0])
      3'b001, 3'b010: digit = a_q;
      3'b011:         digit = a2;
      3'b100:         digit = ~a2 + AW'(1);
      3'b101, 3'b110: digit = ~a_q + AW'(1);
      default:        digit = '0;
    endcase
    sum = p_q[PW-1 -: AW] + digit;
    // bits [2W:1] of the post-shift register, i.e. the product once the last digit is retired
    prod = {sum, p_q[WIDTH:3]};
    state_d = state_q;
    a_d = a_q;
    p_d = p_q;
    cnt_d = cnt_q;
    res_d = res_q;
    exc_d = exc_q;
    if (start) begin
      state_d = RUN;
      a_d = {{2{data_operandA[WIDTH-1]}}, data_operandA};
      p_d = {{AW{1'b0}}, data_operandB, 1'b0};
      cnt_d = CW'(WIDTH / 2);
    end else if (state_q == RUN) begin
      p_d = {{2{sum[AW-1]}}, sum, p_q[WIDTH:2]};
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        state_d = DONE;
        res_d = prod[WIDTH-1:0];
        exc_d = prod[2*WIDTH-1:WIDTH] != {WIDTH{prod[WIDTH-1]}};
      end
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      a_q <= '0;
      p_q <= '0;
      cnt_q <= '0;
      res_q <= '0;
      exc_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      p_q <= p_d;
      cnt_q <= cnt_d;
      res_q <= res_d;
      exc_q <= exc_d;
    end
  end
  assign data_result = res_q;
  assign data_exception = exc_q;
  assign data_resultRDY = state_q == DONE;
  assign busy = state_q == RUN;
endmodule

// File: doc/booth_mult.md
Name: booth_mult

Overview:
- Sequential signed 32x32 multiplier for the multdiv unit, using radix-4 modified Booth recoding with one recoded digit retired per cycle.
- Pairs with the non-restoring divider and uses the same operand, result, exception and ready conventions, so the multdiv wrapper can select between the two units.
- Returns the low 32 bits of the 64-bit product and flags signed overflow.

Parameters:
- WIDTH, 32, operand and result width. Must be even. Step count = WIDTH/2.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous active-high reset; clears all state
- data_operandA  in  32  multiplicand, two's complement
- data_operandB  in  32  multiplier, two's complement
- ctrl_MULT  in  1  start request; sampled on the rising edge
- data_result  out  32  product bits [31:0]
- data_exception  out  1  signed overflow: product does not fit in 32 bits
- data_resultRDY  out  1  one-cycle pulse when data_result and data_exception are valid
- busy  out  1  high while an operation is in progress (RUN state)

Behaviour:
- Reset (async, any time, including mid-operation):
  - state = IDLE, step counter = 0, product register = 0.
  - data_result = 0, data_exception = 0, data_resultRDY = 0, busy = 0.
- States:
  - IDLE --ctrl_MULT--> RUN
  - RUN --counter reaches 0 after last step--> DONE
  - DONE --> IDLE, or DONE --> RUN if ctrl_MULT is high in DONE (back-to-back issue).
- Start edge:
  - Latch A sign-extended to 34 bits.
  - Load the product register with {34'b0, B, 1'b0}.
  - Set counter = WIDTH/2 (16).
  - Operands are sampled only at this edge; operand changes afterwards are ignored.
- RUN, each edge:
  - Recode the low 3 bits of the product register into a digit in {0, +A, +2A, -A, -2A} (000/111 -> 0, 001/010 -> +A, 011 -> +2A, 100 -> -2A, 101/110 -> -A).
  - Add the digit to the upper 34 bits using 34-bit two's-complement arithmetic. Subtraction is invert-plus-one.
  - Arithmetic-shift the whole register right by 2.
  - Decrement the counter.
- Transition to DONE: on the edge that performs the 16th step, counter 1 -> 0.
- DONE (exactly one cycle):
  - data_resultRDY = 1.
  - data_result = P[31:0].
  - data_exception = 1 iff P[63:32] != {32{P[31]}}, where P is the 64-bit signed product.
- Latency: start edge at cycle 0; data_resultRDY is high during cycle 16 (16 edges after the start edge); throughput is one op per 17 cycles.
- ctrl_MULT while in RUN: ignored. No restart and no queuing.
- ctrl_MULT in DONE:
  - The ready pulse still occurs in that cycle.
  - The new operation starts on that edge.
- Output hold:
  - data_result and data_exception are registered.
  - They keep the last completed value until the next DONE.
  - They are not cleared by a new start.
- No exception for zero operands. Any operand may be 0x80000000.
- busy = (state == RUN). data_resultRDY and busy are never high together.

Test Plan:
- 7 x -3, start from IDLE -> data_resultRDY high exactly 16 cycles after the start edge, for one cycle; data_result = 0xFFFFFFEB; data_exception = 0.
- 0x7FFFFFFF x 2 -> data_result = 0xFFFFFFFE, data_exception = 1. Then 0x80000000 x 1 -> data_result = 0x80000000, data_exception = 0.
- 0x80000000 x 0xFFFFFFFF -> data_result = 0x80000000, data_exception = 1. Then 0xFFFF0000 x 0x00010000 -> data_result = 0x00000000, data_exception = 1 (upper word all ones, bit 31 = 0).
- Hold ctrl_MULT high continuously with operands changed every cycle:
  - Only the operands at the first edge and at each DONE edge are used.
  - Ready pulses occur every 17 cycles.
  - Results match the sampled operands.
- Assert reset at cycle 8 of a 12345 x 6789 operation:
  - All outputs go to 0 immediately (asynchronously).
  - No ready pulse appears.
  - A fresh start afterwards gives data_result = 83810205 (0x04FED79D), data_exception = 0.
- Randomised signed operand pairs (at least 10k) against a 64-bit reference model -> data_result and data_exception match; data_result holds between completions.
